divider: RTL and testbench

Sequential signed 32-bit integer divider: the division half of the multdiv unit, complementing the Booth multiplier on the same operand/control/result interface. Computes quotient = dividend / divisor (truncated toward zero) with a restoring shift-subtract datapath, one quotient bit per cycle. It flags divide-by-zero and the single overflow case, and signals completion with a one-cycle ready pulse.

---
 rtl/divider_pkg.sv | 25 ++
 rtl/divider_div_step.sv | 31 +++
 rtl/divider.sv | 122 ++++++++++++
 tb/tb_divider.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the sequential signed divider: state encoding,
// iteration count and operand-magnitude helper.
package divider_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MAG_W     = 33;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned DIV_ITERS = 32;

  localparam logic [DATA_W-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // |x| widened by one bit so that |-2^31| is represented exactly
  function automatic logic [MAG_W-1:0] magnitude(input logic [DATA_W-1:0] x);
    logic [MAG_W-1:0] sx;
    sx = {x[DATA_W-1], x};
    return x[DATA_W-1] ? (~sx + MAG_W'(1)) : sx;
  endfunction

endpackage

// File: rtl/divider_div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract |B|,
// keep the difference and set the quotient bit when it did not go negative.
module divider_div_step
  import divider_pkg::*;
(
  input  logic [MAG_W-1:0]  rem,
  input  logic [DATA_W-1:0] quo,
  input  logic [MAG_W-1:0]  dvs,
  output logic [MAG_W-1:0]  rem_n,
  output logic [DATA_W-1:0] quo_n
);

  logic [MAG_W-1:0] shifted;
  logic [MAG_W:0]   diff;
  logic             unused_rem_msb;

  // Remainder stays below |B| <= 2^31, so its top bit never shifts out
  assign unused_rem_msb = rem[MAG_W-1];
  assign shifted        = {rem[MAG_W-2:0], quo[DATA_W-1]};
  assign diff           = {1'b0, shifted} - {1'b0, dvs};

  always_comb begin
    rem_n = shifted;
    quo_n = {quo[DATA_W-2:0], 1'b0};
    if (!diff[MAG_W]) begin
      rem_n = diff[MAG_W-1:0];
      quo_n = {quo[DATA_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/divider.sv
// Sequential signed 32-bit divider, one quotient bit per cycle, truncating
// toward zero; flags divide-by-zero and INT_MIN / -1 overflow.
module divider
  import divider_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_operandA,
  input  logic [DATA_W-1:0] data_operandB,
  input  logic              ctrl_DIV,
  input  logic              ctrl_MULT,
  output logic [DATA_W-1:0] data_result,
  output logic              data_exception,
  output logic              data_resultRDY
);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              sign_q, ovf_q;
  logic [MAG_W-1:0]  rem_q, dvs_q, rem_n;
  logic [DATA_W-1:0] quo_q, quo_n;
  logic              rdy_d;

  logic              start, b_zero, ovf_case, last_iter;
  logic [MAG_W-1:0]  abs_a;
  logic              unused_abs_a_msb;

  assign start            = ctrl_DIV & ~ctrl_MULT;
  assign b_zero           = (data_operandB == '0);
  assign ovf_case         = (data_operandA == INT_MIN) && (data_operandB == '1);
  assign last_iter        = (cnt_q == CNT_W'(DIV_ITERS - 1));
  assign abs_a            = magnitude(data_operandA);
  // |A| <= 2^31 always fits the 32-bit quotient field
  assign unused_abs_a_msb = abs_a[MAG_W-1];

  divider_div_step u_step (
    .rem   (rem_q),
    .quo   (quo_q),
    .dvs   (dvs_q),
    .rem_n (rem_n),
    .quo_n (quo_n)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and ready pulse; divide-by-zero sits one idle cycle in DONE
  // before pulsing so its ready lands one cycle after the start edge.
  always_comb begin
    state_d = state_q;
    rdy_d   = 1'b0;
    if (ctrl_MULT) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = b_zero ? DONE : RUN;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          if (last_iter) begin
            state_d = DONE;
            rdy_d   = 1'b1;
          end
        end
        DONE: begin
          if (data_resultRDY) begin
            state_d = IDLE;
          end else begin
            rdy_d   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath, counter and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q          <= '0;
      sign_q         <= 1'b0;
      ovf_q          <= 1'b0;
      rem_q          <= '0;
      dvs_q          <= '0;
      quo_q          <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= rdy_d;
      if (ctrl_MULT) begin
        cnt_q          <= '0;
        data_result    <= '0;
        data_exception <= 1'b0;
      end else if (start) begin
        sign_q         <= data_operandA[DATA_W-1] ^ data_operandB[DATA_W-1];
        ovf_q          <= ovf_case;
        quo_q          <= abs_a[DATA_W-1:0];
        dvs_q          <= magnitude(data_operandB);
        rem_q          <= '0;
        cnt_q          <= '0;
        data_result    <= '0;
        data_exception <= b_zero;
      end else if (state_q == RUN) begin
        rem_q <= rem_n;
        quo_q <= quo_n;
        cnt_q <= CNT_W'(cnt_q + 1'b1);
        if (last_iter) begin
          data_result    <= sign_q ? DATA_W'(-quo_n) : quo_n;
          data_exception <= ovf_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed scoreboard bench for the sequential signed divider.
module tb_divider;

  typedef struct packed {
    logic [31:0] res;
    logic        exc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_DIV = 1'b0;
  logic        ctrl_MULT = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  divider dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_DIV       (ctrl_DIV),
    .ctrl_MULT      (ctrl_MULT),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  function automatic exp_t ref_div(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    if (b == 32'd0) begin
      e.res = 32'd0;
      e.exc = 1'b1;
    end else if (a == MIN_INT && b == 32'hFFFF_FFFF) begin
      e.res = MIN_INT;
      e.exc = 1'b1;
    end else begin
      e.res = 32'($signed(a) / $signed(b));
      e.exc = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one start edge (E0); returns #1 after E0
  task automatic go(input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV      = 1'b1;
    sb.push_back(ref_div(a, b));
    @(posedge clock);
    #1;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Wait lat edges after E0; RDY must first rise exactly after edge lat
  task automatic expect_done(input int lat, input string tag);
    int   first;
    exp_t e;
    first = 0;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY && first == 0) first = k;
    end
    check({tag, "_rdy_edge"}, 32'(first), 32'(lat));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_result"}, data_result, e.res);
      check({tag, "_exc"}, 32'(data_exception), 32'(e.exc));
    end else begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end
  endtask

  task automatic expect_no_rdy(input int n, input string tag);
    int seen;
    seen = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) seen++;
    end
    check({tag, "_no_rdy"}, 32'(seen), 32'd0);
  endtask

  task automatic rdy_drops(input string tag);
    @(posedge clock);
    #1;
    check({tag, "_rdy_low"}, 32'(data_resultRDY), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("reset_result", data_result, 32'd0);
    check("reset_exc", 32'(data_exception), 32'd0);
    check("reset_rdy", 32'(data_resultRDY), 32'd0);

    go(32'd100, 32'd7);
    expect_done(32, "pos_pos");
    rdy_drops("pos_pos");

    go(32'hFFFF_FFF9, 32'd2);
    expect_done(32, "neg_pos");
    go(32'd7, 32'hFFFF_FFFE);
    expect_done(32, "pos_neg");
    go(32'hFFFF_FFF9, 32'hFFFF_FFFE);
    expect_done(32, "neg_neg");
    rdy_drops("neg_neg");

    go(32'd5, 32'd0);
    expect_done(1, "div_zero");
    rdy_drops("div_zero");
    go(32'd9, 32'd3);
    check("start_clears_exc", 32'(data_exception), 32'd0);
    expect_done(32, "after_zero");

    go(MIN_INT, 32'hFFFF_FFFF);
    expect_done(32, "overflow");
    go(MIN_INT, 32'd1);
    expect_done(32, "min_by_one");
    rdy_drops("min_by_one");

    // Multiply start aborts the division at E10
    go(32'd100, 32'd7);
    void'(sb.pop_front());
    expect_no_rdy(9, "pre_mult");
    ctrl_MULT = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    check("mult_result", data_result, 32'd0);
    check("mult_exc", 32'(data_exception), 32'd0);
    expect_no_rdy(30, "post_mult");

    // Restart with new operands at E15
    go(32'd100, 32'd7);
    void'(sb.pop_front());
    expect_no_rdy(14, "pre_restart");
    go(32'd20, 32'd3);
    expect_done(32, "restart");
    rdy_drops("restart");

    // Reset at E20
    go(32'd100, 32'd7);
    void'(sb.pop_front());
    expect_no_rdy(19, "pre_reset");
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("mid_reset_result", data_result, 32'd0);
    check("mid_reset_exc", 32'(data_exception), 32'd0);
    check("mid_reset_rdy", 32'(data_resultRDY), 32'd0);
    expect_no_rdy(40, "post_reset");

    // Back-to-back: second start on the edge ending the first RDY
    go(32'd1000, 32'hFFFF_FFF3);
    expect_done(32, "b2b_first");
    go(32'h7FFF_FFFF, 32'd16);
    check("b2b_rdy_low", 32'(data_resultRDY), 32'd0);
    expect_done(32, "b2b_second");
    rdy_drops("b2b_second");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
